// File: rtl/net_packet_injector_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | net_packet_pkg / net_packet_injector_if                                  |
// | Network packet type and the host/network handshake bundle of the         |
// | injector.                                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package net_packet_pkg;
  // Codes 5..7 are unknown ops; they are carried like any other non-NULL op.
  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_BAR   = 3'd3,
    NET_OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    net_op_e     net_op;
    logic [15:0] addr;
    logic [31:0] data;
  } net_packet_s;
endpackage

interface net_packet_injector_if;
  import net_packet_pkg::*;

  logic        in_v_i;
  net_packet_s in_packet_i;
  logic        in_ready_o;
  logic        out_ready_i;
  net_packet_s net_packet_o;

  modport master (
    output in_v_i, in_packet_i, out_ready_i,
    input  in_ready_o, net_packet_o
  );

  modport slave (
    input  in_v_i, in_packet_i, out_ready_i,
    output in_ready_o, net_packet_o
  );
endinterface

`default_nettype wire

// File: rtl/net_packet_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | net_packet_injector                                                      |
// | Buffers host packets in a FIFO and issues them onto the network bus,     |
// | driving NULL on every cycle without an issue.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module net_packet_injector
  import net_packet_pkg::*;
#(
  parameter  int els_p         = 8,
  localparam int count_width_p = $clog2(els_p) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  net_packet_injector_if.slave     bus,
  output logic [count_width_p-1:0] count_o,
  output logic [31:0]              sent_count_o,
  output logic                     pc_sent_o,
  output logic                     idle_o
);

  localparam int addr_width_lp = $clog2(els_p);
  localparam int ptr_width_lp  = count_width_p;

  net_packet_s                 mem_q [els_p];
  logic [ptr_width_lp-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0]     rd_ptr_q, rd_ptr_d;
  net_packet_s                 net_packet_q, net_packet_d;
  logic [31:0]                 sent_count_q, sent_count_d;
  logic                        pc_sent_q, pc_sent_d;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  net_packet_s head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ptr_width_lp-1] != rd_ptr_q[ptr_width_lp-1]) &&
                 (wr_ptr_q[addr_width_lp-1:0] == rd_ptr_q[addr_width_lp-1:0]);
  assign head  = mem_q[rd_ptr_q[addr_width_lp-1:0]];

  // NULL offers complete the handshake but are dropped instead of stored.
  assign push = bus.in_v_i && !full && (bus.in_packet_i.net_op != NET_OP_NULL);
  assign pop  = bus.out_ready_i && !empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + (push ? ptr_width_lp'(1) : '0);
    rd_ptr_d     = rd_ptr_q + (pop ? ptr_width_lp'(1) : '0);
    net_packet_d = pop ? head : '0;
    sent_count_d = sent_count_q + (pop ? 32'd1 : 32'd0);
    pc_sent_d    = pc_sent_q || (pop && (head.net_op == NET_OP_PC));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      net_packet_q <= '0;
      sent_count_q <= '0;
      pc_sent_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      net_packet_q <= net_packet_d;
      sent_count_q <= sent_count_d;
      pc_sent_q    <= pc_sent_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q[addr_width_lp-1:0]] <= bus.in_packet_i;
    end
  end

  assign bus.in_ready_o   = !full;
  assign bus.net_packet_o = net_packet_q;
  assign count_o          = wr_ptr_q - rd_ptr_q;
  assign sent_count_o     = sent_count_q;
  assign pc_sent_o        = pc_sent_q;
  assign idle_o           = empty && (net_packet_q.net_op == NET_OP_NULL);

endmodule

`default_nettype wire

// File: doc/net_packet_injector.md
Name: net_packet_injector

Overview:
- Host-side source of network packets: buffers net_packet_s requests from the test harness/host loader in a FIFO and issues them onto the core network bus, at most one per cycle.
- Its output drives the network bus, which the packet logger and the core's packet decoder both observe.
- Emits a NULL op on every cycle it is not issuing a packet, so downstream consumers never see stale data.
- Tracks issue statistics and raises a sticky flag once a PC (core start) packet has been issued.

Parameters:
- els_p, 8, FIFO depth in packets; power of two, >= 2.
- count_width_p, $clog2(els_p)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- in_v_i  input  1  host offers a packet
- in_packet_i  input  $bits(net_packet_s)  offered packet
- in_ready_o  output  1  injector can accept (FIFO not full)
- out_ready_i  input  1  network may take a packet this cycle
- net_packet_o  output  $bits(net_packet_s)  registered packet onto network bus
- count_o  output  count_width_p  current FIFO occupancy
- sent_count_o  output  32  number of non-NULL packets issued since reset
- pc_sent_o  output  1  sticky; a PC-op packet has been issued
- idle_o  output  1  FIFO empty and net_packet_o.net_op == NULL

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk):
  - FIFO is flushed; read and write pointers go to 0.
  - net_packet_o is all-zero (net_op = NULL).
  - count_o = 0, sent_count_o = 0, pc_sent_o = 0, in_ready_o = 1, idle_o = 1.
  - Reset asserted mid-operation discards all buffered packets. No partial packet reaches the bus after the reset edge.
- Input handshake:
  - in_ready_o = !full. It is combinational from registered state only, never from in_v_i.
  - A packet is accepted when in_v_i && in_ready_o.
  - An accepted packet with net_op == NULL is consumed and discarded: not stored, occupancy unchanged.
  - An accepted packet with any other net_op (INSTR, REG, BAR, PC, or an unknown value) is written at the write pointer.
- FIFO:
  - Pointers are $clog2(els_p)+1 bits wide and wrap naturally.
  - Empty when the pointers are equal. Full when the MSBs differ and the low bits are equal.
  - There is no bypass from input to output.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - When full, no push is possible (in_ready_o = 0), even if a pop occurs in the same cycle.
- Output stage, registered, evaluated each posedge:
  - If out_ready_i && !empty: net_packet_o <= FIFO head, pop, sent_count_o += 1 (wraps at 2^32).
  - If that packet's net_op == PC, pc_sent_o <= 1.
  - Otherwise net_packet_o <= all-zero (NULL).
  - Each issued packet is therefore visible for exactly one cycle.
- Latency: a packet accepted at edge t (FIFO empty, out_ready_i high) is popped at edge t+1 and visible on net_packet_o during cycle t+1 to t+2.
- Ordering: strict FIFO order; no reordering by op type. A PC packet is never issued before earlier INSTR/REG/BAR packets.
- pc_sent_o holds until reset; a later PC packet has no further effect.
- count_o equals write pointer minus read pointer, updated on the same edge as the push/pop.
- idle_o is combinational from registered state.

Test Plan:
- Reset with FIFO holding 3 packets -> after the reset edge: count_o = 0, net_packet_o.net_op = NULL, sent_count_o = 0, in_ready_o = 1; nothing issued afterwards.
- out_ready_i = 1, push INSTR(addr 0x10, data 0xDEADBEEF) then REG(addr 3, data 5) then PC(addr 0x0) on consecutive cycles -> bus shows INSTR, REG, PC on three consecutive cycles starting 2 cycles after the first push. sent_count_o ends at 3; pc_sent_o rises on the edge that issues PC.
- out_ready_i = 0, push els_p = 8 packets -> in_ready_o = 0 and count_o = 8. A 9th offer is not accepted. Raising out_ready_i drains all 8 in order over 8 cycles; in_ready_o returns to 1 after the first pop.
- Push a NULL-op packet with in_v_i = 1 -> count_o stays 0, nothing issued, sent_count_o unchanged.
- FIFO at 4 entries, simultaneous push and pop for 20 cycles -> count_o stays 4, pointers wrap past els_p twice, issued data matches push order.
- out_ready_i toggling 1,0,1,0 with 4 queued packets -> packets appear only on edges where out_ready_i was 1. Each is visible for exactly one cycle, with NULL between them.
